// File: rtl/scipio_if_pkg.sv
// Shared instruction-fetch definitions: fetch FSM state encoding and the NOP word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package scipio_if_pkg;

    localparam int          COMMON_WIDTH = 32;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;   // RV32 addi x0,x0,0

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: runs req/ack with instruction memory for pc_addr and
// registers the fetched word with its PC toward IF/ID.
// Latency: mem_ack in cycle N -> inst_valid in N+1; zero-wait memory sustains 1 inst/cycle.
// Backpressure: fetch_stall holds the PC register unless a fetch is consumed; a downstream
// stall parks acked data in HOLD; flush kills the current and any outstanding fetch.
//
// Ports: clk, rst (async, active-high); pc_addr, stall, flush in from pipeline;
//        mem_req/mem_addr out, mem_ack/mem_rdata in to instruction memory;
//        inst_valid/inst/inst_pc out to IF/ID; fetch_stall out to PC register.
// Build option: define IF_MISALIGN_EXC_EN to add the inst_misalign output; a misaligned
//        pc_addr then produces a NOP slot flagged misaligned instead of a memory request.
module if_fetch
    import scipio_if_pkg::*;
#(
    parameter int          XLEN       = COMMON_WIDTH,
    parameter logic [31:0] RESET_INST = NOP_INST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_addr,
    input  logic            stall,
    input  logic            flush,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
`ifdef IF_MISALIGN_EXC_EN
    output logic            inst_misalign,
`endif
    output logic            fetch_stall
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] req_pc;     // address presented in the most recent REQ cycle
    logic [XLEN-1:0] drop_addr;  // address of the fetch being drained after a flush
    logic            misalign;   // REQ slot replaced by a misaligned-PC marker
    logic            take;       // REQ slot completes this cycle (ack or misalign marker)

`ifdef IF_MISALIGN_EXC_EN
    logic misalign_q;
    assign misalign      = (state == REQ) && (pc_addr[1:0] != 2'b00);
    assign inst_misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    assign take = mem_ack || misalign;

    // PC advances only when an acked fetch is accepted downstream this very cycle.
    assign fetch_stall = !((state == REQ) && mem_ack && !stall && !flush);

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_addr  = '0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                mem_req  = !misalign;
                mem_addr = pc_addr;
                if (flush) begin
                    // A completed slot leaves nothing in flight; otherwise drain it.
                    state_nxt = take ? REQ : DROP;
                end else if (take && stall) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                mem_addr = req_pc;
                if (flush || !stall) state_nxt = REQ;
            end
            DROP: begin
                mem_req  = 1'b1;
                mem_addr = drop_addr;
                if (!flush && mem_ack) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_pc     <= '0;
            drop_addr  <= '0;
            inst_valid <= 1'b0;
            inst       <= RESET_INST;
            inst_pc    <= '0;
`ifdef IF_MISALIGN_EXC_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == REQ) req_pc <= pc_addr;
            if ((state == REQ) && flush && !take) drop_addr <= pc_addr;

            if (flush) begin
                inst_valid <= 1'b0;
`ifdef IF_MISALIGN_EXC_EN
                misalign_q <= 1'b0;
`endif
            end else begin
                case (state)
                    REQ: begin
                        if (misalign) begin
                            inst_valid <= 1'b1;
                            inst       <= RESET_INST;
                            inst_pc    <= pc_addr;
`ifdef IF_MISALIGN_EXC_EN
                            misalign_q <= 1'b1;
`endif
                        end else if (mem_ack) begin
                            inst_valid <= 1'b1;
                            inst       <= mem_rdata;
                            inst_pc    <= pc_addr;
`ifdef IF_MISALIGN_EXC_EN
                            misalign_q <= 1'b0;
`endif
                        end else if (!stall) begin
                            // Stalled valid data is retained until accepted.
                            inst_valid <= 1'b0;
`ifdef IF_MISALIGN_EXC_EN
                            misalign_q <= 1'b0;
`endif
                        end
                    end
                    HOLD: begin
                        // Held word is accepted on the cycle stall drops.
                        if (!stall) begin
                            inst_valid <= 1'b0;
`ifdef IF_MISALIGN_EXC_EN
                            misalign_q <= 1'b0;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed vector table, reset-abort sequence,
// optional misalign sequence, then randomized traffic against a transaction model.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_addr;
    logic        stall, flush, mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_req, inst_valid, fetch_stall;
    logic [31:0] mem_addr, inst, inst_pc;
`ifdef IF_MISALIGN_EXC_EN
    logic        inst_misalign;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .pc_addr     (pc_addr),
        .stall       (stall),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
`ifdef IF_MISALIGN_EXC_EN
        .inst_misalign (inst_misalign),
`endif
        .fetch_stall (fetch_stall)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_addr,
                                 input logic e_fs, input logic e_v,
                                 input logic [31:0] e_inst, input logic [31:0] e_ipc);
        check({tag, ".mem_req"},     {31'd0, mem_req},     {31'd0, e_req});
        check({tag, ".mem_addr"},    mem_addr,             e_addr);
        check({tag, ".fetch_stall"}, {31'd0, fetch_stall}, {31'd0, e_fs});
        check({tag, ".inst_valid"},  {31'd0, inst_valid},  {31'd0, e_v});
        check({tag, ".inst"},        inst,                 e_inst);
        check({tag, ".inst_pc"},     inst_pc,              e_ipc);
    endtask

    // Directed vector: inputs held for one cycle, expected outputs seen during that cycle.
    typedef struct {
        logic [31:0] pc;
        logic        stall, flush, ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_fs, e_v;
        logic [31:0] e_inst, e_ipc;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] pc, input logic st, input logic fl,
                                input logic ack, input logic [31:0] rd,
                                input logic er, input logic [31:0] ea, input logic ef,
                                input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.pc = pc; v.stall = st; v.flush = fl; v.ack = ack; v.rdata = rd;
        v.e_req = er; v.e_addr = ea; v.e_fs = ef; v.e_v = ev; v.e_inst = ei; v.e_ipc = ep;
        return v;
    endfunction

    // Transaction-level reference: tracks whether fetching has started, whether an
    // acked word is parked for a stalled consumer, and whether a killed fetch is draining.
    bit          m_started, m_parked, m_draining;
    logic [31:0] m_last_pc, m_drain_pc;
    bit          m_valid;
    logic [31:0] m_inst, m_ipc;

    task automatic model_reset();
        m_started = 0; m_parked = 0; m_draining = 0;
        m_last_pc = 0; m_drain_pc = 0;
        m_valid = 0; m_inst = 32'h0000_0013; m_ipc = 0;
    endtask

    task automatic model_expect(output logic e_req, output logic [31:0] e_addr, output logic e_fs);
        bit fetching;
        fetching = m_started && !m_parked && !m_draining;
        e_req  = m_draining || fetching;
        e_addr = m_draining ? m_drain_pc : m_parked ? m_last_pc : fetching ? pc_addr : 32'h0;
        // The PC register moves only when a fetched word is taken by the pipeline now.
        e_fs   = !(fetching && mem_ack && !stall && !flush);
    endtask

    task automatic model_step();
        if (!m_started) begin
            m_started = 1;
        end else if (m_draining) begin
            if (!flush && mem_ack) m_draining = 0;
        end else if (m_parked) begin
            if (flush || !stall) begin
                m_parked = 0;
                m_valid  = 0;
            end
        end else begin
            m_last_pc = pc_addr;
            if (flush) begin
                m_valid = 0;
                if (!mem_ack) begin
                    m_draining = 1;
                    m_drain_pc = pc_addr;
                end
            end else if (mem_ack) begin
                m_valid = 1; m_inst = mem_rdata; m_ipc = pc_addr;
                m_parked = stall;
            end else if (!stall) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 0; flush = 0; mem_ack = 0; mem_rdata = 0; pc_addr = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    vec_t tv[21];

    initial begin
        logic        e_req, e_fs;
        logic [31:0] e_addr;

        tv[0]  = mk(32'h000, 0, 0, 0, 32'hBAD0_0000, 0, 32'h000, 1, 0, 32'h0000_0013, 32'h000);
        tv[1]  = mk(32'h000, 0, 0, 1, 32'h1111_0000, 1, 32'h000, 0, 0, 32'h0000_0013, 32'h000);
        tv[2]  = mk(32'h004, 0, 0, 1, 32'h1111_0004, 1, 32'h004, 0, 1, 32'h1111_0000, 32'h000);
        tv[3]  = mk(32'h008, 0, 0, 1, 32'h1111_0008, 1, 32'h008, 0, 1, 32'h1111_0004, 32'h004);
        tv[4]  = mk(32'h010, 0, 0, 0, 32'hBAD0_0001, 1, 32'h010, 1, 1, 32'h1111_0008, 32'h008);
        tv[5]  = mk(32'h010, 0, 0, 0, 32'hBAD0_0002, 1, 32'h010, 1, 0, 32'h1111_0008, 32'h008);
        tv[6]  = mk(32'h010, 0, 0, 0, 32'hBAD0_0003, 1, 32'h010, 1, 0, 32'h1111_0008, 32'h008);
        tv[7]  = mk(32'h010, 0, 0, 1, 32'h2222_0010, 1, 32'h010, 0, 0, 32'h1111_0008, 32'h008);
        tv[8]  = mk(32'h020, 1, 0, 1, 32'h3333_0020, 1, 32'h020, 1, 1, 32'h2222_0010, 32'h010);
        tv[9]  = mk(32'h020, 1, 0, 1, 32'hBAD0_0004, 0, 32'h020, 1, 1, 32'h3333_0020, 32'h020);
        tv[10] = mk(32'h020, 1, 0, 0, 32'hBAD0_0005, 0, 32'h020, 1, 1, 32'h3333_0020, 32'h020);
        tv[11] = mk(32'h024, 0, 0, 0, 32'hBAD0_0006, 0, 32'h020, 1, 1, 32'h3333_0020, 32'h020);
        tv[12] = mk(32'h024, 0, 0, 1, 32'h3333_0024, 1, 32'h024, 0, 0, 32'h3333_0020, 32'h020);
        tv[13] = mk(32'h030, 0, 0, 0, 32'hBAD0_0007, 1, 32'h030, 1, 1, 32'h3333_0024, 32'h024);
        tv[14] = mk(32'h030, 0, 1, 0, 32'hBAD0_0008, 1, 32'h030, 1, 0, 32'h3333_0024, 32'h024);
        tv[15] = mk(32'h100, 0, 0, 0, 32'hBAD0_0009, 1, 32'h030, 1, 0, 32'h3333_0024, 32'h024);
        tv[16] = mk(32'h100, 0, 0, 1, 32'hDEAD_0030, 1, 32'h030, 1, 0, 32'h3333_0024, 32'h024);
        tv[17] = mk(32'h100, 0, 0, 1, 32'h4444_0100, 1, 32'h100, 0, 0, 32'h3333_0024, 32'h024);
        tv[18] = mk(32'h104, 0, 0, 1, 32'h4444_0104, 1, 32'h104, 0, 1, 32'h4444_0100, 32'h100);
        tv[19] = mk(32'h108, 1, 1, 1, 32'hDEAD_0108, 1, 32'h108, 1, 1, 32'h4444_0104, 32'h104);
        tv[20] = mk(32'h200, 0, 0, 0, 32'hBAD0_000A, 1, 32'h200, 1, 0, 32'h4444_0104, 32'h104);

        // Directed table: back-to-back, wait states, hold, flush/drop, flush+stall+ack.
        do_reset();
        check("reset.inst_valid", {31'd0, inst_valid}, 32'd0);
        check("reset.inst", inst, 32'h0000_0013);
        for (int i = 0; i < 21; i++) begin
            pc_addr = tv[i].pc; stall = tv[i].stall; flush = tv[i].flush;
            mem_ack = tv[i].ack; mem_rdata = tv[i].rdata;
            @(negedge clk);
            check_outputs($sformatf("vec%0d", i), tv[i].e_req, tv[i].e_addr, tv[i].e_fs,
                          tv[i].e_v, tv[i].e_inst, tv[i].e_ipc);
            @(posedge clk); #1;
        end

        // Reset mid-REQ aborts at once; a late ack after reset is ignored.
        stall = 0; flush = 0; mem_ack = 0; pc_addr = 32'h200;
        #2 rst = 1'b1;
        #1 check_outputs("rst_async", 0, 32'h0, 1, 0, 32'h0000_0013, 32'h0);
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("late_ack.idle_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1 mem_ack = 0;
        @(negedge clk);
        check("late_ack.inst_valid", {31'd0, inst_valid}, 32'd0);
        check("late_ack.inst", inst, 32'h0000_0013);

`ifdef IF_MISALIGN_EXC_EN
        // Misaligned PC yields a flagged NOP slot without touching memory.
        pc_addr = 32'h42; mem_ack = 0;
        @(negedge clk);
        check("misalign.mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        check("misalign.inst_valid", {31'd0, inst_valid}, 32'd1);
        check("misalign.inst", inst, 32'h0000_0013);
        check("misalign.flag", {31'd0, inst_misalign}, 32'd1);
        check("misalign.inst_pc", inst_pc, 32'h42);
        @(posedge clk); #1;
`endif

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            pc_addr   = $urandom & 32'hFFFF_FFFC;
            stall     = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            mem_ack   = ($urandom_range(0, 1) == 1);
            mem_rdata = $urandom;
            @(negedge clk);
            model_expect(e_req, e_addr, e_fs);
            check_outputs($sformatf("rand%0d", c), e_req, e_addr, e_fs, m_valid, m_inst, m_ipc);
            model_step();
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage that sits directly downstream of the PC register. It takes the current fetch address, runs a request/acknowledge transaction with instruction memory, and presents the fetched word with its PC to the IF/ID pipeline register. It back-pressures the PC register while memory is busy and discards in-flight fetches on a control-flow redirect.

## Interface
- XLEN, 32, address/data width (COMMON_WIDTH)
- RESET_INST, 32'h0000_0013, instruction word driven while invalid (RV32 NOP)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pc_addr  in  XLEN  fetch address from PC register
- stall  in  1  downstream (IF/ID) cannot accept an instruction
- flush  in  1  redirect (jump/branch taken); kill current and outstanding fetch
- mem_req  out  1  instruction-memory request
- mem_addr  out  XLEN  request address
- mem_ack  in  1  memory returns mem_rdata this cycle
- mem_rdata  in  XLEN  fetched word
- inst_valid  out  1  inst/inst_pc valid to IF/ID
- inst  out  XLEN  fetched instruction
- inst_pc  out  XLEN  PC of inst
- fetch_stall  out  1  hold PC register (drives its stall input)

## Operation
- States: IDLE, REQ, HOLD, DROP.
- IDLE: entered only from reset; next cycle → REQ.
- REQ: mem_req=1, mem_addr=pc_addr; req_pc latched each cycle. On mem_ack and no flush: inst<=mem_rdata, inst_pc<=pc_addr, inst_valid<=1; stay REQ if !stall, else → HOLD. No ack: inst_valid<=0 (only if !stall; stalled valid data is retained).
- HOLD: mem_req=0, outputs held; when stall drops → REQ (inst_valid cleared next cycle unless new ack).
- DROP: mem_req=1, mem_addr=drop_addr (address latched at flush); on mem_ack data discarded → REQ.
- flush (any state, priority over everything): inst_valid<=0 next edge. REQ without ack → DROP, latching pc_addr as drop_addr. REQ with ack same cycle → data discarded, stay REQ. HOLD → REQ. DROP stays DROP.
- fetch_stall = !(state==REQ && mem_ack && !stall && !flush); PC register advances only on a consumed fetch.
- Addresses used unmodified; no arithmetic in this block.

## Timing
- Reset values: mem_req=0, mem_addr=0, inst_valid=0, inst=RESET_INST, inst_pc=0, fetch_stall=1, state=IDLE.
- Latency: ack in cycle N → inst_valid at N+1. Zero-wait memory gives 1 instruction/cycle.
- mem_addr stable from first req cycle until ack (guaranteed by fetch_stall).
- stall and flush same cycle: flush wins, inst_valid cleared.
- rst mid-transaction: immediate abort to IDLE; a late mem_ack after reset is ignored (IDLE ignores ack).

## Configuration
- IF_MISALIGN_EXC_EN defined: adds output inst_misalign (1 bit, reset 0); when pc_addr[1:0]!=0 in REQ, no mem_req issued, inst_valid<=1, inst=RESET_INST, inst_misalign<=1 for that slot.
- Undefined: port absent, pc_addr[1:0] ignored, request issued as-is.

## Structure
- Shared package scipio_if_pkg: fetch_state_t enum (IDLE, REQ, HOLD, DROP), NOP_INST constant.
- Single module, no sub-module; FSM plus output registers.

## Test plan
- Reset then zero-wait memory, pc_addr 0,4,8 → inst_valid from cycle 2, inst_pc 0,4,8 back-to-back, fetch_stall 0 each ack.
- mem_ack delayed 3 cycles at pc 0x10 → mem_req/mem_addr=0x10 held 4 cycles, fetch_stall=1, inst_valid=0 until cycle after ack.
- stall high 2 cycles after valid inst at 0x20 → inst/inst_pc stable, mem_req=0 in HOLD, resumes at 0x24.
- flush while waiting on 0x30 → DROP, ack word discarded (never valid), next valid inst_pc = redirected pc_addr 0x100.
- rst asserted mid-REQ → all outputs at reset values same cycle, late ack ignored.
- IF_MISALIGN_EXC_EN, pc_addr 0x42 → no mem_req, inst_misalign=1, inst=0x00000013.
